// File: rtl/alu_muldiv.sv
// 32-bit ALU with single-cycle logic/arithmetic and a sequential signed multiply/divide unit
// that updates HI/LO. Multiply is 32-step shift-add, divide is 32-step restoring division.
module alu_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  ALU_Ctrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        Zero,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;
  localparam logic [1:0] StFix  = 2'd3;

  localparam logic [3:0] OpDiv  = 4'b1000;
  localparam logic [3:0] OpMult = 4'b1001;

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [32:0] acc_q, acc_d;    // product high half / partial remainder / raw A on div-by-zero
  logic [31:0] work_q, work_d;  // multiplier shifting out / quotient shifting in
  logic [32:0] opr_q, opr_d;    // multiplicand or divisor magnitude
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic        is_div_q, is_div_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic [32:0] mag_a, mag_b;
  logic        is_mult_op, is_div_op, accept;
  logic [33:0] mul_sum;
  logic [32:0] rem_shift;
  logic [33:0] div_diff;
  logic [63:0] prod_mag, prod_signed;
  logic [31:0] quot_signed, rem_signed;

  // 33-bit magnitudes so that -2^31 maps to +2^31 without overflow.
  assign mag_a = A[31] ? ({1'b0, ~A} + 33'd1) : {1'b0, A};
  assign mag_b = B[31] ? ({1'b0, ~B} + 33'd1) : {1'b0, B};

  assign is_mult_op = (ALU_Ctrl == OpMult);
  assign is_div_op  = (ALU_Ctrl == OpDiv);
  assign accept     = start && (state_q == StIdle) && (is_mult_op || is_div_op);

  always_comb begin
    mul_sum = {1'b0, acc_q};
    if (work_q[0]) begin
      mul_sum = {1'b0, acc_q} + {1'b0, opr_q};
    end
  end

  assign rem_shift = {acc_q[31:0], work_q[31]};
  assign div_diff  = {1'b0, rem_shift} - {1'b0, opr_q};

  assign prod_mag    = {acc_q[31:0], work_q};
  assign prod_signed = neg_q ? (64'd0 - prod_mag) : prod_mag;
  assign quot_signed = neg_q ? (32'd0 - work_q) : work_q;
  assign rem_signed  = neg_rem_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    work_d    = work_q;
    opr_d     = opr_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          neg_d     = A[31] ^ B[31];
          neg_rem_d = A[31];
          count_d   = 5'd0;
          is_div_d  = is_div_op;
          dz_d      = 1'b0;
          if (is_mult_op) begin
            acc_d   = 33'd0;
            work_d  = mag_b[31:0];
            opr_d   = mag_a;
            state_d = StMul;
          end else if (B == 32'd0) begin
            acc_d   = {1'b0, A};
            work_d  = 32'd0;
            opr_d   = 33'd0;
            dz_d    = 1'b1;
            state_d = StFix;
          end else begin
            acc_d   = 33'd0;
            work_d  = mag_a[31:0];
            opr_d   = mag_b;
            state_d = StDiv;
          end
        end
      end

      StMul: begin
        // Add then shift the 65-bit {acc, work} pair right by one.
        acc_d   = mul_sum[33:1];
        work_d  = {mul_sum[0], work_q[31:1]};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = StFix;
        end
      end

      StDiv: begin
        if (!div_diff[33]) begin
          acc_d  = div_diff[32:0];
          work_d = {work_q[30:0], 1'b1};
        end else begin
          acc_d  = rem_shift;
          work_d = {work_q[30:0], 1'b0};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = StFix;
        end
      end

      StFix: begin
        if (dz_q) begin
          hi_d = acc_q[31:0];
          lo_d = 32'hFFFF_FFFF;
        end else if (is_div_q) begin
          hi_d = rem_signed;
          lo_d = quot_signed;
        end else begin
          hi_d = prod_signed[63:32];
          lo_d = prod_signed[31:0];
        end
        done_d  = 1'b1;
        count_d = 5'd0;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= 5'd0;
      acc_q     <= 33'd0;
      work_q    <= 32'd0;
      opr_q     <= 33'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      work_q    <= work_d;
      opr_q     <= opr_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      is_div_q  <= is_div_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;

  // Single-cycle result path; independent of start and of the multi-cycle FSM.
  always_comb begin
    Result = 32'd0;
    unique case (ALU_Ctrl)
      4'b1100, 4'b1101, 4'b0000, 4'b0101: Result = A + B;
      4'b0001, 4'b0110:                   Result = A - B;
      4'b0010:                            Result = A & B;
      4'b0011:                            Result = A | B;
      4'b0100:                            Result = ~(A | B);
      4'b0111: Result = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
      4'b1010:                            Result = hi_q;
      4'b1011:                            Result = lo_q;
      default:                            Result = 32'd0;
    endcase
  end

  assign Zero = (Result == 32'd0);

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomized scoreboard bench for alu_muldiv: driver queues expected HI/LO per op, a monitor
// checks them on each done pulse via MFHI/MFLO.
module tb_alu_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  ALU_Ctrl;
  logic [31:0] A, B;
  logic [31:0] Result;
  logic        Zero, busy, done;

  localparam logic [3:0] OP_DIV  = 4'b1000;
  localparam logic [3:0] OP_MULT = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;
  logic [63:0] sb[$];
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  alu_muldiv dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ALU_Ctrl (ALU_Ctrl),
    .A        (A),
    .B        (B),
    .Result   (Result),
    .Zero     (Zero),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: plain 64-bit signed arithmetic, SV division truncates toward zero.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sbv, p, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (op == OP_MULT) begin
      p  = sa * sbv;
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      q  = sa / sbv;
      r  = sa % sbv;
      hi = r[31:0];
      lo = q[31:0];
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'b1100, 4'b1101, 4'b0000, 4'b0101: return a + b;
      4'b0001, 4'b0110: return a - b;
      4'b0010: return a & b;
      4'b0011: return a | b;
      4'b0100: return ~(a | b);
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1010: return hi_m;
      4'b1011: return lo_m;
      default: return 32'd0;
    endcase
  endfunction

  // Idle-time single-cycle op; called at posedge+1.
  task automatic single(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] e;
    ALU_Ctrl = op;
    A = a;
    B = b;
    #1;
    e = ref_alu(op, a, b);
    check({name, "_result"}, Result, e);
    check({name, "_zero"}, {31'd0, Zero}, {31'd0, e == 32'd0});
  endtask

  // Issue a MULT/DIV; must be called at posedge+1. Returns at posedge+1.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ehi, elo, e;
    int nb, exp_busy;
    bit got;
    model_op(op, a, b, ehi, elo);
    sb.push_back({ehi, elo});
    exp_busy = (op == OP_DIV && b == 32'd0) ? 1 : 33;
    start = 1'b1;
    ALU_Ctrl = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    ALU_Ctrl = OP_MFHI;
    nb = 0;
    got = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
      if (busy) nb++;
      if (i == 2 && busy) check("mfhi_while_busy", Result, hi_m);
      if (i == 3 && busy) begin
        #1;
        ALU_Ctrl = 4'($urandom_range(0, 15));
        A = $urandom;
        B = $urandom;
        #1;
        e = ref_alu(ALU_Ctrl, A, B);
        check("single_during_busy", Result, e);
        ALU_Ctrl = OP_MFHI;
      end
      if (i == 4 && busy) begin
        #1;
        start = 1'b1;
        ALU_Ctrl = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_MULT;
        A = $urandom;
        B = $urandom;
      end
      if (i == 5) begin
        #1;
        start = 1'b0;
        ALU_Ctrl = OP_MFHI;
      end
    end
    check("done_seen", {31'd0, got}, 32'd1);
    check("busy_cycles", nb, exp_busy);
    hi_m = ehi;
    lo_m = elo;
    @(posedge clk);
    #1;
    ALU_Ctrl = OP_MFLO;
    @(negedge clk);
    check("zero_on_mflo", {31'd0, Zero}, {31'd0, elo == 32'd0});
    @(posedge clk);
    #1;
  endtask

  // Monitor: each done pulse must match the oldest queued expectation.
  initial begin
    logic [63:0] e;
    bit ok;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = (sb.size() != 0);
        check("done_expected", {31'd0, ok}, 32'd1);
        if (ok) begin
          e = sb.pop_front();
          check("hi", Result, e[63:32]);
          @(negedge clk);
          check("lo", Result, e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] op;
    logic [31:0] a, b;
    rst = 1'b1;
    start = 1'b0;
    ALU_Ctrl = OP_MFHI;
    A = 32'd0;
    B = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_hi", Result, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // First edge with rst low accepts.
    run_op(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    single("mfhi_after", OP_MFHI, 32'd0, 32'd0);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    run_op(OP_DIV, 32'h0000_0005, 32'h0000_0000);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0);

    // Reset at iteration 10 of a MULT: op discarded, HI/LO cleared, no done.
    start = 1'b1;
    ALU_Ctrl = OP_MULT;
    A = 32'h0000_1234;
    B = 32'h0000_5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    ALU_Ctrl = OP_MFHI;
    repeat (10) @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_hi", Result, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    @(posedge clk);
    #1;
    ALU_Ctrl = OP_MFLO;
    @(negedge clk);
    check("rst_mid_lo", Result, 32'd0);
    repeat (40) @(posedge clk);
    #1;

    single("beq", 4'b0001, 32'h0000_1234, 32'h0000_1234);
    single("slt", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    single("nor", 4'b0100, 32'h0, 32'h0);
    single("add_wrap", 4'b0000, 32'h7FFF_FFFF, 32'h0000_0001);
    single("sub_wrap", 4'b0110, 32'h0, 32'h1);

    for (int k = 0; k < 16; k++) begin
      op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_MULT;
      a = pick();
      b = pick();
      run_op(op, a, b);
    end
    for (int k = 0; k < 30; k++) begin
      single("rand_single", 4'($urandom_range(0, 15)), pick(), pick());
      @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
